// File: rtl/conv_pkg.sv
// Shared FSM state and multiplier tap-select encodings for the 3-tap convolution sequencer.
// Pure definitions only; no latency or flow control involved.
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE0,
        ST_ISSUE1,
        ST_ISSUE2,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [1:0] SEL_IDLE = 2'b00;
    localparam logic [1:0] SEL_TAP0 = 2'b01;
    localparam logic [1:0] SEL_TAP1 = 2'b10;
    localparam logic [1:0] SEL_TAP2 = 2'b11;

endpackage

// File: rtl/conv3_sequencer_if.sv
// Operand, multiplier and result bus of the 3-tap sequencer; slave = sequencer, master = environment.
// Operand and result sides use valid/ready; the multiplier side has a fixed one-cycle return.
interface conv3_sequencer_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a0, a1, a2;
    logic [DW-1:0] k0, k1, k2;

    logic [1:0]    mul_sel;
    logic [DW-1:0] mul_a0, mul_a1, mul_a2;
    logic [DW-1:0] mul_k0, mul_k1, mul_k2;
    logic [DW-1:0] mul_product;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] result;
    logic [DW+1:0] sum_full;
    logic          sat;

    modport slave (
        input  in_valid, a0, a1, a2, k0, k1, k2, mul_product, out_ready,
        output in_ready, mul_sel, mul_a0, mul_a1, mul_a2, mul_k0, mul_k1, mul_k2,
               out_valid, result, sum_full, sat
    );

    modport master (
        output in_valid, a0, a1, a2, k0, k1, k2, mul_product, out_ready,
        input  in_ready, mul_sel, mul_a0, mul_a1, mul_a2, mul_k0, mul_k1, mul_k2,
               out_valid, result, sum_full, sat
    );

endinterface

// File: rtl/conv3_sequencer.sv
// Sequences three taps through an external registered multiplier and accumulates a 3-tap dot product.
// Result valid 5 cycles after acceptance; held in DONE until out_ready; one operand set in flight at a time.
module conv3_sequencer
    import conv_pkg::*;
#(
    parameter int DW     = 8,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    conv3_sequencer_if.slave bus
);

    localparam logic [DW+1:0] MAX_VAL = {2'b00, {DW{1'b1}}};

    state_t        state, state_nxt;
    logic          accept;
    logic          acc_add;
    logic [1:0]    sel;
    logic [DW+1:0] acc;
    logic [DW-1:0] op_a0, op_a1, op_a2;
    logic [DW-1:0] op_k0, op_k1, op_k2;
    logic          over;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sel       = SEL_IDLE;
        accept    = 1'b0;
        acc_add   = 1'b0;
        case (state)
            ST_IDLE: begin
                accept = bus.in_valid;
                if (bus.in_valid) state_nxt = ST_ISSUE0;
            end
            ST_ISSUE0: begin
                sel       = SEL_TAP0;
                state_nxt = ST_ISSUE1;
            end
            // Each product returns one cycle after its select, so the add lags issue by one state.
            ST_ISSUE1: begin
                sel       = SEL_TAP1;
                acc_add   = 1'b1;
                state_nxt = ST_ISSUE2;
            end
            ST_ISSUE2: begin
                sel       = SEL_TAP2;
                acc_add   = 1'b1;
                state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                acc_add   = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            op_a0 <= '0;
            op_a1 <= '0;
            op_a2 <= '0;
            op_k0 <= '0;
            op_k1 <= '0;
            op_k2 <= '0;
        end else if (accept) begin
            acc   <= '0;
            op_a0 <= bus.a0;
            op_a1 <= bus.a1;
            op_a2 <= bus.a2;
            op_k0 <= bus.k0;
            op_k1 <= bus.k1;
            op_k2 <= bus.k2;
        end else if (acc_add) begin
            acc <= acc + {2'b00, bus.mul_product};
        end
    end

    // acc is frozen from DONE until the next acceptance, so the result fields need no extra register.
    assign over = (acc > MAX_VAL);

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.mul_sel   = sel;
    assign bus.mul_a0    = op_a0;
    assign bus.mul_a1    = op_a1;
    assign bus.mul_a2    = op_a2;
    assign bus.mul_k0    = op_k0;
    assign bus.mul_k1    = op_k1;
    assign bus.mul_k2    = op_k2;
    assign bus.sum_full  = acc;
    assign bus.sat       = over;
    assign bus.result    = (SAT_EN && over) ? {DW{1'b1}} : acc[DW-1:0];

endmodule

// File: tb/tb_conv3_sequencer.sv
// Directed bench: two sequencers (saturating and wrapping) share stimulus; multiplier modelled as registered (a*k)>>1.
module tb_conv3_sequencer;
    import conv_pkg::*;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] a0 = '0, a1 = '0, a2 = '0, k0 = '0, k1 = '0, k2 = '0;
    logic          force_en = 1'b0;
    logic [DW-1:0] p0 = '0, p1 = '0;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    conv3_sequencer_if #(.DW(DW)) if0 ();
    conv3_sequencer_if #(.DW(DW)) if1 ();

    assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
    assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;
    assign if0.a0 = a0; assign if0.a1 = a1; assign if0.a2 = a2;
    assign if0.k0 = k0; assign if0.k1 = k1; assign if0.k2 = k2;
    assign if1.a0 = a0; assign if1.a1 = a1; assign if1.a2 = a2;
    assign if1.k0 = k0; assign if1.k1 = k1; assign if1.k2 = k2;
    assign if0.mul_product = p0;
    assign if1.mul_product = p1;

    conv3_sequencer #(.DW(DW), .SAT_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(if0));
    conv3_sequencer #(.DW(DW), .SAT_EN(1'b0)) dut_ns (.clk(clk), .rst(rst), .bus(if1));

    function automatic logic [DW-1:0] mul_model(input logic [1:0] s, input logic fe,
                                                input logic [DW-1:0] x0, x1, x2, y0, y1, y2);
        logic [2*DW-1:0] pr;
        pr = '0;
        case (s)
            2'b01: pr = fe ? 16'd200 : ({8'b0, x0} * {8'b0, y0}) >> 1;
            2'b10: pr = fe ? 16'd100 : ({8'b0, x1} * {8'b0, y1}) >> 1;
            2'b11: pr = fe ? 16'd50  : ({8'b0, x2} * {8'b0, y2}) >> 1;
            default: pr = '0;
        endcase
        return pr[DW-1:0];
    endfunction

    always_ff @(posedge clk) begin
        p0 <= mul_model(if0.mul_sel, force_en, if0.mul_a0, if0.mul_a1, if0.mul_a2,
                        if0.mul_k0, if0.mul_k1, if0.mul_k2);
        p1 <= mul_model(if1.mul_sel, force_en, if1.mul_a0, if1.mul_a1, if1.mul_a2,
                        if1.mul_k0, if1.mul_k1, if1.mul_k2);
    end

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_ops(input logic [DW-1:0] x0, x1, x2, y0, y1, y2);
        a0 = x0; a1 = x1; a2 = x2; k0 = y0; k1 = y1; k2 = y2;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        n_cmp++; if (if0.mul_sel !== 2'b00) begin n_fail++; $display("FAIL rst_mul_sel got %b want 00", if0.mul_sel); end
        n_cmp++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", if0.out_valid); end
        n_cmp++; if (if0.result !== 8'd0) begin n_fail++; $display("FAIL rst_result got %0d want 0", if0.result); end
        n_cmp++; if (if0.sum_full !== 10'd0) begin n_fail++; $display("FAIL rst_sum_full got %0d want 0", if0.sum_full); end
        n_cmp++; if (if0.sat !== 1'b0) begin n_fail++; $display("FAIL rst_sat got %b want 0", if0.sat); end
        n_cmp++; if ({if0.mul_a0, if0.mul_a2, if0.mul_k1} !== 24'd0) begin n_fail++; $display("FAIL rst_operands got %h want 0", {if0.mul_a0, if0.mul_a2, if0.mul_k1}); end
        rst = 1'b0;
        tick;
        n_cmp++; if (if0.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", if0.in_ready); end
    endtask

    task automatic test_basic;
        set_ops(8'd4, 8'd6, 8'd8, 8'd10, 8'd2, 8'd3);
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        n_cmp++; if (if0.mul_sel !== SEL_TAP0) begin n_fail++; $display("FAIL basic_sel_t1 got %b want 01", if0.mul_sel); end
        n_cmp++; if (if0.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_in_ready_t1 got %b want 0", if0.in_ready); end
        n_cmp++; if ({if0.mul_a0, if0.mul_a1, if0.mul_a2, if0.mul_k0, if0.mul_k1, if0.mul_k2} !== {8'd4, 8'd6, 8'd8, 8'd10, 8'd2, 8'd3})
            begin n_fail++; $display("FAIL basic_operands got %h want 04060 80a0203", {if0.mul_a0, if0.mul_a1, if0.mul_a2, if0.mul_k0, if0.mul_k1, if0.mul_k2}); end
        tick;
        n_cmp++; if (if0.mul_sel !== SEL_TAP1) begin n_fail++; $display("FAIL basic_sel_t2 got %b want 10", if0.mul_sel); end
        n_cmp++; if (if0.mul_product !== 8'd20) begin n_fail++; $display("FAIL basic_prod0 got %0d want 20", if0.mul_product); end
        tick;
        n_cmp++; if (if0.mul_sel !== SEL_TAP2) begin n_fail++; $display("FAIL basic_sel_t3 got %b want 11", if0.mul_sel); end
        n_cmp++; if (if0.mul_product !== 8'd6) begin n_fail++; $display("FAIL basic_prod1 got %0d want 6", if0.mul_product); end
        tick;
        n_cmp++; if (if0.mul_sel !== SEL_IDLE) begin n_fail++; $display("FAIL basic_sel_t4 got %b want 00", if0.mul_sel); end
        n_cmp++; if (if0.mul_product !== 8'd12) begin n_fail++; $display("FAIL basic_prod2 got %0d want 12", if0.mul_product); end
        n_cmp++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_out_valid_t4 got %b want 0", if0.out_valid); end
        tick;
        n_cmp++; if (if0.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid_t5 got %b want 1", if0.out_valid); end
        n_cmp++; if (if0.result !== 8'd38) begin n_fail++; $display("FAIL basic_result got %0d want 38", if0.result); end
        n_cmp++; if (if0.sum_full !== 10'd38) begin n_fail++; $display("FAIL basic_sum_full got %0d want 38", if0.sum_full); end
        n_cmp++; if (if0.sat !== 1'b0) begin n_fail++; $display("FAIL basic_sat got %b want 0", if0.sat); end
        n_cmp++; if (if1.result !== 8'd38) begin n_fail++; $display("FAIL basic_result_nosat got %0d want 38", if1.result); end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        n_cmp++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_out_valid_t6 got %b want 0", if0.out_valid); end
        n_cmp++; if (if0.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready_t6 got %b want 1", if0.in_ready); end
    endtask

    task automatic test_saturation;
        force_en = 1'b1;
        set_ops(8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (4) tick;
        n_cmp++; if (if0.out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_out_valid got %b want 1", if0.out_valid); end
        n_cmp++; if (if0.sum_full !== 10'd350) begin n_fail++; $display("FAIL sat_sum_full got %0d want 350", if0.sum_full); end
        n_cmp++; if (if0.sat !== 1'b1) begin n_fail++; $display("FAIL sat_flag got %b want 1", if0.sat); end
        n_cmp++; if (if0.result !== 8'd255) begin n_fail++; $display("FAIL sat_result got %0d want 255", if0.result); end
        n_cmp++; if (if1.result !== 8'd94) begin n_fail++; $display("FAIL sat_result_wrap got %0d want 94", if1.result); end
        n_cmp++; if (if1.sat !== 1'b1) begin n_fail++; $display("FAIL sat_flag_wrap got %b want 1", if1.sat); end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        force_en = 1'b0;
    endtask

    task automatic test_backpressure;
        set_ops(8'd4, 8'd6, 8'd8, 8'd10, 8'd2, 8'd3);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (4) tick;
        set_ops(8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (if0.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d] got %b want 1", i, if0.out_valid); end
            n_cmp++; if (if0.result !== 8'd38) begin n_fail++; $display("FAIL bp_result[%0d] got %0d want 38", i, if0.result); end
            n_cmp++; if (if0.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, if0.in_ready); end
            n_cmp++; if (if0.mul_a0 !== 8'd4) begin n_fail++; $display("FAIL bp_mul_a0[%0d] got %0d want 4", i, if0.mul_a0); end
            tick;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        n_cmp++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid got %b want 0", if0.out_valid); end
        n_cmp++; if (if0.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got %b want 1", if0.in_ready); end
        n_cmp++; if (if0.mul_k0 !== 8'd10) begin n_fail++; $display("FAIL bp_release_mul_k0 got %0d want 10", if0.mul_k0); end
    endtask

    task automatic test_reset_midop;
        int seen;
        set_ops(8'd4, 8'd6, 8'd8, 8'd10, 8'd2, 8'd3);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        n_cmp++; if (if0.mul_sel !== SEL_TAP1) begin n_fail++; $display("FAIL midrst_sel_t2 got %b want 10", if0.mul_sel); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_cmp++; if (if0.mul_sel !== SEL_IDLE) begin n_fail++; $display("FAIL midrst_sel got %b want 00", if0.mul_sel); end
        n_cmp++; if (if0.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got %b want 1", if0.in_ready); end
        n_cmp++; if (if0.sum_full !== 10'd0) begin n_fail++; $display("FAIL midrst_sum_full got %0d want 0", if0.sum_full); end
        n_cmp++; if (if0.mul_a0 !== 8'd0) begin n_fail++; $display("FAIL midrst_mul_a0 got %0d want 0", if0.mul_a0); end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (if0.out_valid === 1'b1) seen++;
            tick;
        end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL midrst_no_out_valid got %0d cycles want 0", seen); end
        set_ops(8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (4) tick;
        n_cmp++; if (if0.out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_fresh_valid got %b want 1", if0.out_valid); end
        n_cmp++; if (if0.result !== 8'd28) begin n_fail++; $display("FAIL midrst_fresh_result got %0d want 28", if0.result); end
        n_cmp++; if (if0.sum_full !== 10'd28) begin n_fail++; $display("FAIL midrst_fresh_sum got %0d want 28", if0.sum_full); end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        int n_acc, n_res, acc0, acc1;
        logic [DW-1:0] r0, r1;
        logic acc_now;
        n_acc = 0; n_res = 0; acc0 = 0; acc1 = 0; r0 = '0; r1 = '0;
        out_ready = 1'b1;
        set_ops(8'd4, 8'd6, 8'd8, 8'd10, 8'd2, 8'd3);
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            acc_now = in_valid && (if0.in_ready === 1'b1);
            if (if0.out_valid === 1'b1) begin
                if (n_res == 0) r0 = if0.result;
                else if (n_res == 1) r1 = if0.result;
                n_res++;
            end
            if (acc_now) begin
                if (n_acc == 0) acc0 = cyc;
                else acc1 = cyc;
                n_acc++;
            end
            tick;
            if (acc_now && n_acc == 1) set_ops(8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7);
            if (acc_now && n_acc == 2) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_cmp++; if (n_acc !== 2) begin n_fail++; $display("FAIL b2b_accepts got %0d want 2", n_acc); end
        n_cmp++; if (acc1 - acc0 !== 6) begin n_fail++; $display("FAIL b2b_spacing got %0d want 6", acc1 - acc0); end
        n_cmp++; if (n_res !== 2) begin n_fail++; $display("FAIL b2b_results got %0d want 2", n_res); end
        n_cmp++; if (r0 !== 8'd38) begin n_fail++; $display("FAIL b2b_result0 got %0d want 38", r0); end
        n_cmp++; if (r1 !== 8'd28) begin n_fail++; $display("FAIL b2b_result1 got %0d want 28", r1); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_saturation;
        test_backpressure;
        test_reset_midop;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/conv3_sequencer.md
CONV3_SEQUENCER -- requirements
Module: conv3_sequencer

Interface
REQ-001 Parameter DW, 8, operand and product width.
REQ-002 Parameter SAT_EN, 1, when 1 result saturates to 2^DW-1; when 0 result is the low DW bits of the sum.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand set offered.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 a0,a1,a2,k0,k1,k2  input  DW each  activation/kernel taps, sampled on acceptance.
REQ-008 mul_sel  output  2  tap select to the multiplier mux: 00 idle, 01 tap0, 10 tap1, 11 tap2.
REQ-009 mul_a0..mul_a2, mul_k0..mul_k2  output  DW each  registered copies of accepted operands, driven to the multiplier.
REQ-010 mul_product  input  DW  registered multiplier output, valid one cycle after the corresponding mul_sel.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 result  output  DW  final (optionally saturated) dot product.
REQ-014 sum_full  output  DW+2  unsaturated 3-tap sum.
REQ-015 sat  output  1  sum_full exceeded 2^DW-1 (valid with out_valid).

Function
REQ-016 States: IDLE, ISSUE0, ISSUE1, ISSUE2, DRAIN, DONE.
REQ-017 in_ready = 1 only in IDLE; acceptance = in_valid & in_ready.
REQ-018 On acceptance (cycle T): operands latched, accumulator cleared, next state ISSUE0.
REQ-019 mul_sel = 01 in ISSUE0 (T+1), 10 in ISSUE1 (T+2), 11 in ISSUE2 (T+3), 00 in IDLE, DRAIN, DONE.
REQ-020 Accumulator adds mul_product in ISSUE1 (tap0), ISSUE2 (tap1), DRAIN (tap2, T+4); no add in other states.
REQ-021 Accumulator width DW+2, zero-extended products, no overflow possible.
REQ-022 DRAIN -> DONE unconditionally; out_valid = 1 from T+5 while in DONE.
REQ-023 result, sum_full, sat stable throughout DONE; sat = (sum_full > 2^DW-1).
REQ-024 DONE -> IDLE when out_ready = 1; out_valid low the following cycle.
REQ-025 in_valid during DONE is not accepted even when out_ready = 1; minimum accepted-to-accepted spacing is 6 cycles.
REQ-026 in_valid while not IDLE is ignored; operand outputs unchanged until next acceptance.
REQ-027 mul_a*/mul_k* hold latched values from T+1 until next acceptance.

Reset
REQ-028 rst high at any clock edge forces IDLE, mul_sel = 00, out_valid = 0, accumulator = 0, result = 0, sum_full = 0, sat = 0, all mul_a*/mul_k* = 0.
REQ-029 rst mid-operation (any non-IDLE state) aborts without producing out_valid; in_ready = 1 in the first cycle after rst deasserts.
REQ-030 rst has priority over acceptance and out_ready in the same cycle.

Structure
REQ-031 State enum, SEL_IDLE/SEL_TAP0/SEL_TAP1/SEL_TAP2 encodings shared in package conv_pkg.
REQ-032 Single module, no sub-module; accumulator and saturation inline; multiplier is external.

Verification (bench models the multiplier as one-cycle registered (a*k)>>1 truncated to DW)
REQ-033 Basic: a=(4,6,8), k=(10,2,3) -> mul_sel 01,10,11 at T+1..T+3; products 20,6,12; out_valid at T+5, result=38, sum_full=38, sat=0.
REQ-034 Saturation: products forced 200,100,50 -> sum_full=350, sat=1, result=255 (SAT_EN=1); result=94 (SAT_EN=0).
REQ-035 Backpressure: out_ready held 0 for 10 cycles -> out_valid and result=38 stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-036 Reset mid-op: rst at T+2 -> next cycle mul_sel=00, out_valid never asserts, in_ready=1; following operands produce correct fresh result.
REQ-037 Back-to-back: in_valid held high with two operand sets, out_ready=1 -> acceptances exactly 6 cycles apart, second result uses second set only.
